ctrl_pipe: RTL and testbench

- Consumer end of the decoder's 11-bit control word.
- Carries the control word and the instruction PC through the ID/EX, EX/MEM and MEM/WB stage registers.
- Inserts bubbles on stall, squashes on taken branch/jump, and turns the decode exception bit into a precise exception (EPC/cause capture plus flush) at EX.
- Emits per-stage enables to the datapath.

---
 rtl/ctrl_pkg.sv | 35 +++
 rtl/ctrl_stage_reg.sv | 43 ++++
 rtl/ctrl_pipe.sv | 177 +++++++++++++++++
 tb/tb_ctrl_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-word pipeline: field map, cause codes,
// exception FSM encoding.
package ctrl_pkg;

    localparam int CW  = 11;
    localparam int PCW = 32;

    localparam int CTRL_JUMP     = 10;
    localparam int CTRL_BRANCH   = 9;
    localparam int CTRL_MEMTOREG = 8;
    localparam int CTRL_MEMWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_ALUOP_HI = 5;
    localparam int CTRL_ALUOP_LO = 4;
    localparam int CTRL_EXC      = 3;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_REGDST   = 0;

    localparam logic [4:0] EXC_CODE_RI = 5'd10;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } exc_state_e;

    // Only a real instruction carrying the decode exception bit may fault.
    function automatic logic ctrl_faults(
        input logic [CW-1:0] ctrl,
        input logic          valid
    );
        return valid & ctrl[CTRL_EXC];
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline stage register: control word, PC and valid bit.
// Bubble takes priority over load and clears all three fields.
module ctrl_stage_reg #(
    parameter int CW  = 11,
    parameter int PCW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic           bubble_i,
    input  logic [CW-1:0]  ctrl_i,
    input  logic [PCW-1:0] pc_i,
    input  logic           valid_i,
    output logic [CW-1:0]  ctrl_o,
    output logic [PCW-1:0] pc_o,
    output logic           valid_o
);

    logic [CW-1:0]  ctrl_q;
    logic [PCW-1:0] pc_q;
    logic           valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            ctrl_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            ctrl_q  <= ctrl_i;
            pc_q    <= pc_i;
            valid_q <= valid_i;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline ID/EX -> EX/MEM -> MEM/WB with bubbles, squash and
// precise exception capture at EX. Optional counters: CTRL_PIPE_PERF_EN.
module ctrl_pipe #(
    parameter int         CW          = ctrl_pkg::CW,
    parameter int         PCW         = ctrl_pkg::PCW,
    parameter logic [4:0] EXC_CODE_RI = ctrl_pkg::EXC_CODE_RI
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [CW-1:0]  id_ctrl,
    input  logic [PCW-1:0] id_pc,
    input  logic           id_valid,
    input  logic           stall,
    input  logic           ex_taken,
    input  logic           exc_ack,
    output logic [CW-1:0]  ex_ctrl,
    output logic [CW-1:0]  mem_ctrl,
    output logic [CW-1:0]  wb_ctrl,
    output logic [PCW-1:0] ex_pc,
    output logic           flush_if_id,
    output logic           exc_valid,
    output logic [PCW-1:0] epc,
    output logic [4:0]     cause
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]    bubble_cnt,
    output logic [31:0]    flush_cnt,
    output logic [31:0]    exc_cnt
`endif
);

    import ctrl_pkg::*;

    exc_state_e     state_q;
    logic           exc_valid_q;
    logic [PCW-1:0] epc_q;
    logic [4:0]     cause_q;

    logic [CW-1:0]  ex_ctrl_q;
    logic [PCW-1:0] ex_pc_q;
    logic           ex_valid_q;
    logic [CW-1:0]  mem_ctrl_q;
    logic [PCW-1:0] mem_pc_q;
    logic           mem_valid_q;
    logic [CW-1:0]  wb_ctrl_q;
    logic [PCW-1:0] wb_pc_q;
    logic           wb_valid_q;

    logic in_exc;
    logic exc_cap;
    logic ex_bubble;
    logic mem_bubble;
    logic unused_wb_bits;

    assign in_exc  = (state_q == ST_EXC);
    assign exc_cap = ~in_exc & ctrl_faults(ex_ctrl_q, ex_valid_q);

    // Exception outranks a taken branch; stall and taken both just bubble.
    assign ex_bubble  = in_exc | exc_cap | stall | ex_taken;
    assign mem_bubble = exc_cap;

    assign flush_if_id = rst_n & (ex_taken | exc_cap | in_exc);

    ctrl_stage_reg #(
        .CW  (CW),
        .PCW (PCW)
    ) u_ex_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (1'b1),
        .bubble_i (ex_bubble),
        .ctrl_i   (id_ctrl),
        .pc_i     (id_pc),
        .valid_i  (id_valid),
        .ctrl_o   (ex_ctrl_q),
        .pc_o     (ex_pc_q),
        .valid_o  (ex_valid_q)
    );

    ctrl_stage_reg #(
        .CW  (CW),
        .PCW (PCW)
    ) u_mem_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (1'b1),
        .bubble_i (mem_bubble),
        .ctrl_i   (ex_ctrl_q),
        .pc_i     (ex_pc_q),
        .valid_i  (ex_valid_q),
        .ctrl_o   (mem_ctrl_q),
        .pc_o     (mem_pc_q),
        .valid_o  (mem_valid_q)
    );

    ctrl_stage_reg #(
        .CW  (CW),
        .PCW (PCW)
    ) u_wb_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (1'b1),
        .bubble_i (1'b0),
        .ctrl_i   (mem_ctrl_q),
        .pc_i     (mem_pc_q),
        .valid_i  (mem_valid_q),
        .ctrl_o   (wb_ctrl_q),
        .pc_o     (wb_pc_q),
        .valid_o  (wb_valid_q)
    );

    // WB PC and valid are carried for the datapath's benefit only.
    assign unused_wb_bits = ^{wb_pc_q, wb_valid_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            exc_valid_q <= 1'b0;
            epc_q       <= '0;
            cause_q     <= '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (exc_cap) begin
                        state_q     <= ST_EXC;
                        exc_valid_q <= 1'b1;
                        epc_q       <= ex_pc_q;
                        cause_q     <= EXC_CODE_RI;
                    end
                end
                ST_EXC: begin
                    if (exc_ack) begin
                        state_q     <= ST_RUN;
                        exc_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] exc_cnt_q;
    logic        stall_bubble;

    assign stall_bubble = stall & ~ex_taken & ~in_exc & ~exc_cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
            exc_cnt_q    <= '0;
        end else begin
            if (stall_bubble && bubble_cnt_q != 32'hFFFF_FFFF)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (ex_taken && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
            if (exc_cap && exc_cnt_q != 32'hFFFF_FFFF)
                exc_cnt_q <= exc_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign exc_cnt    = exc_cnt_q;
`endif

    assign ex_ctrl   = ex_ctrl_q;
    assign mem_ctrl  = mem_ctrl_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign ex_pc     = ex_pc_q;
    assign exc_valid = exc_valid_q;
    assign epc       = epc_q;
    assign cause     = cause_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed scenarios plus random traffic
// checked against an instruction-level model.
module tb_ctrl_pipe;

    localparam logic [10:0] W_R   = 11'b00000100011;
    localparam logic [10:0] W_LW  = 11'b00101000110;
    localparam logic [10:0] W_SW  = 11'b00010000100;
    localparam logic [10:0] W_BEQ = 11'b01000010000;
    localparam logic [10:0] W_EXC = 11'b00000001000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] id_ctrl;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        stall;
    logic        ex_taken;
    logic        exc_ack;
    logic [10:0] ex_ctrl;
    logic [10:0] mem_ctrl;
    logic [10:0] wb_ctrl;
    logic [31:0] ex_pc;
    logic        flush_if_id;
    logic        exc_valid;
    logic [31:0] epc;
    logic [4:0]  cause;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_ctrl     (id_ctrl),
        .id_pc       (id_pc),
        .id_valid    (id_valid),
        .stall       (stall),
        .ex_taken    (ex_taken),
        .exc_ack     (exc_ack),
        .ex_ctrl     (ex_ctrl),
        .mem_ctrl    (mem_ctrl),
        .wb_ctrl     (wb_ctrl),
        .ex_pc       (ex_pc),
        .flush_if_id (flush_if_id),
        .exc_valid   (exc_valid),
        .epc         (epc),
        .cause       (cause)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h t=%0t", n, act, req, $time);
        end
    endfunction

    // One in-flight instruction slot; ld marks a word taken from ID.
    typedef struct {
        logic [10:0] ctrl;
        logic [31:0] pc;
        logic        v;
        logic        ld;
    } ent_t;

    typedef struct {
        logic [10:0] ex;
        logic [10:0] mem;
        logic [10:0] wb;
        logic [31:0] ex_pc;
        logic        pc_chk;
        logic        exc;
        logic [31:0] epc;
        logic [4:0]  cause;
        logic        flush;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_en = 1'b0;

    // slot 0 = EX, 1 = MEM, 2 = WB
    ent_t        pipe [3];
    logic        m_exc;
    logic [31:0] m_epc;
    logic [4:0]  m_cause;

    function automatic ent_t bubble_ent();
        ent_t b;
        b.ctrl = '0;
        b.pc   = '0;
        b.v    = 1'b0;
        b.ld   = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = bubble_ent();
        m_exc   = 1'b0;
        m_epc   = '0;
        m_cause = '0;
    endtask

    // Entered and left at posedge+2; drives one cycle of ID/hazard inputs.
    task automatic cycle(input logic [10:0] c, input logic [31:0] pc,
                         input logic v, input logic st,
                         input logic tk, input logic ak);
        exp_t e;
        ent_t nx;
        logic faulting;
        id_ctrl  = c;
        id_pc    = pc;
        id_valid = v;
        stall    = st;
        ex_taken = tk;
        exc_ack  = ak;
        faulting = !m_exc && pipe[0].v && pipe[0].ctrl[3];
        e.ex     = pipe[0].ctrl;
        e.mem    = pipe[1].ctrl;
        e.wb     = pipe[2].ctrl;
        e.ex_pc  = pipe[0].pc;
        e.pc_chk = pipe[0].ld;
        e.exc    = m_exc;
        e.epc    = m_epc;
        e.cause  = m_cause;
        e.flush  = tk || m_exc || faulting;
        exp_q.push_back(e);
        if (faulting) begin
            m_exc   = 1'b1;
            m_epc   = pipe[0].pc;
            m_cause = 5'd10;
        end else if (m_exc && ak) begin
            m_exc = 1'b0;
        end
        nx.ctrl = c;
        nx.pc   = pc;
        nx.v    = v;
        nx.ld   = 1'b1;
        pipe[2] = pipe[1];
        pipe[1] = faulting ? bubble_ent() : pipe[0];
        pipe[0] = (e.exc || faulting || st || tk) ? bubble_ent() : nx;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic ak);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b0, 1'b0, ak);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow act=empty req=entry t=%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ex_ctrl", 32'(ex_ctrl), 32'(mon_e.ex));
                chk("mem_ctrl", 32'(mem_ctrl), 32'(mon_e.mem));
                chk("wb_ctrl", 32'(wb_ctrl), 32'(mon_e.wb));
                chk("flush_if_id", 32'(flush_if_id), 32'(mon_e.flush));
                chk("exc_valid", 32'(exc_valid), 32'(mon_e.exc));
                chk("epc", epc, mon_e.epc);
                chk("cause", 32'(cause), 32'(mon_e.cause));
                if (mon_e.pc_chk) chk("ex_pc", ex_pc, mon_e.ex_pc);
            end
        end
    end

    task automatic chk_all_zero(string tag);
        chk({tag, "_ex_ctrl"}, 32'(ex_ctrl), 0);
        chk({tag, "_mem_ctrl"}, 32'(mem_ctrl), 0);
        chk({tag, "_wb_ctrl"}, 32'(wb_ctrl), 0);
        chk({tag, "_ex_pc"}, ex_pc, 0);
        chk({tag, "_flush"}, 32'(flush_if_id), 0);
        chk({tag, "_exc_valid"}, 32'(exc_valid), 0);
        chk({tag, "_epc"}, epc, 0);
        chk({tag, "_cause"}, 32'(cause), 0);
    endtask

    initial begin
        logic [10:0] rc;
        rst_n    = 1'b0;
        id_ctrl  = '0;
        id_pc    = '0;
        id_valid = 1'b0;
        stall    = 1'b0;
        ex_taken = 1'b0;
        exc_ack  = 1'b0;
        model_reset();
        #12;
        chk_all_zero("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        mon_en = 1'b1;

        // straight flow
        cycle(W_R, 32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        // stall twice with lw held in ID
        cycle(W_LW, 32'h0040_0004, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(W_LW, 32'h0040_0004, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(W_LW, 32'h0040_0004, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        // taken branch squashes the wrong-path word in ID
        cycle(W_BEQ, 32'h0040_0008, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(W_R, 32'h0040_000C, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
        // precise exception behind an older sw
        cycle(W_SW, 32'h0040_000C, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(W_EXC, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(W_R, 32'h0040_0014, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("dir_epc", epc, 32'h0040_0010);
        chk("dir_cause", 32'(cause), 32'd10);
        chk("dir_exc_valid", 32'(exc_valid), 32'd1);
        chk("dir_sw_wb", 32'(wb_ctrl), 32'(W_SW));
        cycle(W_R, 32'h0040_0014, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(W_R, 32'h0040_0014, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("dir_exc_ack", 32'(exc_valid), 32'd0);
        idle(3, 1'b0);
        // flagged but invalid word never faults
        cycle(W_EXC, 32'h0040_0020, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        // exception vs taken vs stall in the same cycle
        cycle(W_EXC, 32'h0050_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(W_LW, 32'h0050_0004, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);
        idle(3, 1'b0);

        for (int i = 0; i < 600; i++) begin
            rc    = 11'($urandom);
            rc[3] = ($urandom_range(0, 9) == 0);
            cycle(rc, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0);
        end
        idle(2, 1'b1);

        // asynchronous reset with the pipe full of lw words
        for (int i = 0; i < 4; i++)
            cycle(W_LW, 32'h0060_0000 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
        mon_en   = 1'b0;
        ex_taken = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        ex_taken = 1'b0;
        id_ctrl  = '0;
        id_pc    = '0;
        id_valid = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        mon_en = 1'b1;
        cycle(W_R, 32'h0070_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        mon_en = 1'b0;
        chk("sb_leftover", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
